// File: rtl/sysa_sched.sv
// rtl/sysa_sched.sv - sequencer for an NxN weight-stationary systolic array
//
// Loads weight rows into arr_w, skews accepted input vectors onto arr_in,
// gates the array with arr_en and deskews the column sums into one aligned
// result beat with valid/ready backpressure.
//
// Optional feature macro: SYSA_SCHED_PERF_EN adds perf_vec / perf_stall.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   w_valid/w_ready/w_data       weight row beats, w_data[8c+7:8c] = w[row][c]
//   x_valid/x_ready/x_data/x_last input vectors, lane r feeds array row r
//   res_valid/res_ready/res_data/res_last  aligned column sums (16 bit each)
//   arr_en                       array enable
//   arr_w                        held weights, w[r][c] at [8(Nr+c) +: 8]
//   arr_in                       skewed row inputs
//   arr_out                      array column outputs
//   busy                         high outside IDLE
//   perf_vec, perf_stall         saturating counters (SYSA_SCHED_PERF_EN only)

module sysa_sched #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [8*N-1:0]       w_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [8*N-1:0]       x_data,
    input  logic                 x_last,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [16*N-1:0]      res_data,
    output logic                 res_last,
    output logic                 arr_en,
    output logic [8*N*N-1:0]     arr_w,
    output logic [8*N-1:0]       arr_in,
    input  logic [16*N-1:0]      arr_out,
`ifdef SYSA_SCHED_PERF_EN
    output logic [31:0]          perf_vec,
    output logic [31:0]          perf_stall,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    // Tag stages after the entry register so the tag reaches res_valid
    // on the same edge as the last deskewed column.
    localparam int TL = 2 * N - 1;

    state_t          state, state_nxt;
    logic [RW-1:0]   row_cnt;
    logic            stall, w_fire, x_fire, res_fire;

    logic [8*N-1:0]  ent_data;
    logic            ent_v, ent_l;
    logic [TL-1:0]   tag_v, tag_l;
    logic [16*N-1:0] col_al;

    assign stall    = res_valid && !res_ready;
    assign w_fire   = w_valid && w_ready;
    assign x_fire   = x_valid && x_ready;
    assign res_fire = res_valid && res_ready;

    // State register and weight row counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (w_fire) begin
                row_cnt <= (row_cnt == RW'(N - 1)) ? '0 : row_cnt + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (w_fire) begin
                    state_nxt = (N == 1) ? S_STREAM : S_LOAD;
                end else if (x_fire) begin
                    state_nxt = x_last ? S_DRAIN : S_STREAM;
                end
            end
            S_LOAD: begin
                if (w_fire && row_cnt == RW'(N - 1)) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (x_fire && x_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_fire && res_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; a weight beat wins over a vector in IDLE
    always_comb begin
        w_ready = 1'b0;
        x_ready = 1'b0;
        arr_en  = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE: begin
                w_ready = 1'b1;
                x_ready = !w_valid && !stall;
                busy    = 1'b0;
            end
            S_LOAD: begin
                w_ready = 1'b1;
            end
            S_STREAM: begin
                x_ready = !stall;
                arr_en  = !stall;
            end
            S_DRAIN: begin
                arr_en  = !stall;
            end
            default: ;
        endcase
    end

    // Weight rows are written only on beat handshakes and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_w <= '0;
        end else if (w_fire) begin
            arr_w[8*N*int'(row_cnt) +: 8*N] <= w_data;
        end
    end

    // Skew-line entry: accepted vector or zeros, tagged {valid, last}
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_data <= '0;
            ent_v    <= 1'b0;
            ent_l    <= 1'b0;
        end else if (!stall) begin
            ent_data <= x_fire ? x_data : '0;
            ent_v    <= x_fire;
            ent_l    <= x_fire && x_last;
        end
    end

    // Lane r gets r extra delay stages past the entry register
    for (genvar r = 0; r < N; r++) begin : g_lane
        if (r == 0) begin : g_pass
            assign arr_in[7:0] = ent_data[7:0];
        end else begin : g_dly
            logic [7:0] sk [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) sk[k] <= '0;
                end else if (!stall) begin
                    sk[0] <= ent_data[8*r +: 8];
                    for (int k = 1; k < r; k++) sk[k] <= sk[k-1];
                end
            end
            assign arr_in[8*r +: 8] = sk[r-1];
        end
    end

    // Tag pipeline runs alongside the array + deskew path
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            tag_l <= '0;
        end else if (!stall) begin
            tag_v[0] <= ent_v;
            tag_l[0] <= ent_l;
            for (int k = 1; k < TL; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_l[k] <= tag_l[k-1];
            end
        end
    end

    // Column c emerges c cycles after column 0, so it needs N-1-c stages
    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_direct
            assign col_al[16*c +: 16] = arr_out[16*c +: 16];
        end else begin : g_dly
            logic [15:0] dk [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dk[k] <= '0;
                end else if (!stall) begin
                    dk[0] <= arr_out[16*c +: 16];
                    for (int k = 1; k < D; k++) dk[k] <= dk[k-1];
                end
            end
            assign col_al[16*c +: 16] = dk[D-1];
        end
    end

    // Result register; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_data  <= '0;
        end else if (!stall) begin
            res_valid <= tag_v[TL-1];
            res_last  <= tag_l[TL-1];
            res_data  <= col_al;
        end
    end

`ifdef SYSA_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_vec   <= '0;
            perf_stall <= '0;
        end else begin
            if (x_fire && perf_vec != '1) perf_vec <= perf_vec + 32'd1;
            if (stall && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sysa_sched.sv
// tb/tb_sysa_sched.sv - directed self-checking bench for sysa_sched (N=3)

module tb_sysa_sched;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            w_valid = 1'b0;
    logic            w_ready;
    logic [8*N-1:0]  w_data = '0;
    logic            x_valid = 1'b0;
    logic            x_ready;
    logic [8*N-1:0]  x_data = '0;
    logic            x_last = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [16*N-1:0] res_data;
    logic            res_last;
    logic            arr_en;
    logic [8*N*N-1:0] arr_w;
    logic [8*N-1:0]  arr_in;
    logic [16*N-1:0] arr_out;
    logic            busy;
`ifdef SYSA_SCHED_PERF_EN
    logic [31:0]     perf_vec, perf_stall;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] xv [$];
    logic        xl [$];
    logic [47:0] got_d [$];
    logic        got_l [$];
    int          en_low, en_bad, hold_bad;

    always #5 clk = ~clk;

    sysa_sched #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .arr_en(arr_en), .arr_w(arr_w), .arr_in(arr_in), .arr_out(arr_out),
`ifdef SYSA_SCHED_PERF_EN
        .perf_vec(perf_vec), .perf_stall(perf_stall),
`endif
        .busy(busy)
    );

    // Behavioural weight-stationary array: inputs move right, sums move down
    logic [7:0]  a_reg [N][N];
    logic [15:0] p_reg [N][N];
    logic [7:0]  ain;
    logic [15:0] pin;

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_reg[r][c] <= '0;
                    p_reg[r][c] <= '0;
                end
        end else if (arr_en) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    if (c == 0) ain = arr_in[8*r +: 8];
                    else        ain = a_reg[r][c-1];
                    if (r == 0) pin = '0;
                    else        pin = p_reg[r-1][c];
                    a_reg[r][c] <= ain;
                    p_reg[r][c] <= pin + 16'(ain) * 16'(arr_w[8*(N*r+c) +: 8]);
                end
        end
    end

    always_comb begin
        arr_out = '0;
        for (int c = 0; c < N; c++) arr_out[16*c +: 16] = p_reg[N-1][c];
    end

    task automatic load_weights(input logic [23:0] r0, input logic [23:0] r1, input logic [23:0] r2);
        logic [23:0] rows [3];
        rows[0] = r0; rows[1] = r1; rows[2] = r2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = rows[k];
            @(posedge clk);
        end
        @(negedge clk);
        w_valid = 1'b0;
        w_data  = '0;
    endtask

    // Drives xv/xl and collects results; optionally stalls 3 cycles
    // after stall_after results have been taken.
    task automatic run_stream(input int stall_after);
        got_d.delete();
        got_l.delete();
        en_low = 0; en_bad = 0; hold_bad = 0;
        fork
            begin
                int i = 0;
                int guard = 0;
                logic fire;
                while (i < xv.size() && guard < 200) begin
                    @(negedge clk);
                    x_valid = 1'b1;
                    x_data  = xv[i];
                    x_last  = xl[i];
                    #1;
                    fire = x_ready;
                    @(posedge clk);
                    if (fire) i++;
                    guard++;
                end
                @(negedge clk);
                x_valid = 1'b0;
                x_last  = 1'b0;
                x_data  = '0;
            end
            begin
                int guard = 0;
                int scnt = 0;
                logic [47:0] held = '0;
                while (got_d.size() < xv.size() && guard < 300) begin
                    @(negedge clk);
                    guard++;
                    res_ready = !(stall_after >= 0 && got_d.size() == stall_after && scnt < 3);
                    #1;
                    if (busy && !arr_en) en_low++;
                    if (!res_ready) begin
                        scnt++;
                        if (arr_en !== 1'b0) en_bad++;
                        if (scnt == 1) held = res_data;
                        else if (res_data !== held) hold_bad++;
                        if (res_valid !== 1'b1) hold_bad++;
                    end else if (res_valid) begin
                        got_d.push_back(res_data);
                        got_l.push_back(res_last);
                    end
                end
                res_ready = 1'b1;
            end
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        vectors++; if (res_last !== 1'b0) begin miscompares++; $display("FAIL rst_res_last got %b exp 0", res_last); end
        vectors++; if (res_data !== '0) begin miscompares++; $display("FAIL rst_res_data got %h exp 0", res_data); end
        vectors++; if (arr_en !== 1'b0) begin miscompares++; $display("FAIL rst_arr_en got %b exp 0", arr_en); end
        vectors++; if (arr_in !== '0) begin miscompares++; $display("FAIL rst_arr_in got %h exp 0", arr_in); end
        vectors++; if (arr_w !== '0) begin miscompares++; $display("FAIL rst_arr_w got %h exp 0", arr_w); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
        vectors++; if (w_ready !== 1'b1) begin miscompares++; $display("FAIL rst_w_ready got %b exp 1", w_ready); end
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL rst_x_ready got %b exp 1", x_ready); end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int k;
        load_weights(24'h000001, 24'h000100, 24'h010000);
        #1;
        vectors++; if (arr_w !== 72'h010000_000100_000001) begin miscompares++; $display("FAIL id_arr_w got %h exp 010000000100000001", arr_w); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL id_busy_stream got %b exp 1", busy); end
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL id_x_ready got %b exp 1", x_ready); end
        x_valid = 1'b1; x_data = 24'h030201; x_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0; x_last = 1'b0; x_data = '0;
        k = 0;
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        vectors++; if (k !== 6) begin miscompares++; $display("FAIL id_latency got %0d exp 6", k); end
        vectors++; if (res_data !== {16'd3, 16'd2, 16'd1}) begin miscompares++; $display("FAIL id_res_data got %h exp 000300020001", res_data); end
        vectors++; if (res_last !== 1'b1) begin miscompares++; $display("FAIL id_res_last got %b exp 1", res_last); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL id_idle_after got busy %b exp 0", busy); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL id_res_valid_after got %b exp 0", res_valid); end
    endtask

    task automatic set_b2b_stream();
        xv.delete(); xl.delete();
        xv.push_back(24'h030201); xl.push_back(1'b0);
        xv.push_back(24'h060504); xl.push_back(1'b0);
        xv.push_back(24'h010000); xl.push_back(1'b0);
        xv.push_back(24'h000007); xl.push_back(1'b1);
    endtask

    task automatic check_b2b_results(input string tag);
        logic [47:0] exp_d [4];
        logic [47:0] g;
        logic        gl;
        exp_d[0] = {3{16'd12}};
        exp_d[1] = {3{16'd30}};
        exp_d[2] = {3{16'd2}};
        exp_d[3] = {3{16'd14}};
        vectors++; if (got_d.size() !== 4) begin miscompares++; $display("FAIL %s_count got %0d exp 4", tag, got_d.size()); end
        for (int i = 0; i < 4; i++) begin
            g  = (i < got_d.size()) ? got_d[i] : 48'hx;
            gl = (i < got_l.size()) ? got_l[i] : 1'bx;
            vectors++; if (g !== exp_d[i]) begin miscompares++; $display("FAIL %s_data[%0d] got %h exp %h", tag, i, g, exp_d[i]); end
            vectors++; if (gl !== (i == 3)) begin miscompares++; $display("FAIL %s_last[%0d] got %b exp %b", tag, i, gl, (i == 3)); end
        end
    endtask

    task automatic test_back_to_back();
        load_weights(24'h020202, 24'h020202, 24'h020202);
        vectors++; if (arr_w !== {9{8'h02}}) begin miscompares++; $display("FAIL b2b_arr_w got %h exp all 02", arr_w); end
        set_b2b_stream();
        run_stream(-1);
        check_b2b_results("b2b");
        vectors++; if (en_low !== 0) begin miscompares++; $display("FAIL b2b_en_low got %0d exp 0", en_low); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_after got busy %b exp 0", busy); end
    endtask

    task automatic test_stall();
        set_b2b_stream();
        run_stream(1);
        check_b2b_results("stall");
        vectors++; if (en_low !== 3) begin miscompares++; $display("FAIL stall_en_low got %0d exp 3", en_low); end
        vectors++; if (en_bad !== 0) begin miscompares++; $display("FAIL stall_arr_en_high got %0d exp 0", en_bad); end
        vectors++; if (hold_bad !== 0) begin miscompares++; $display("FAIL stall_hold got %0d exp 0", hold_bad); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_idle_after got busy %b exp 0", busy); end
    endtask

    task automatic test_both_valid();
        @(negedge clk);
        w_valid = 1'b1; w_data = 24'h030201;
        x_valid = 1'b1; x_data = 24'h010101; x_last = 1'b1;
        #1;
        vectors++; if (x_ready !== 1'b0) begin miscompares++; $display("FAIL both_x_ready_idle got %b exp 0", x_ready); end
        vectors++; if (w_ready !== 1'b1) begin miscompares++; $display("FAIL both_w_ready_idle got %b exp 1", w_ready); end
        @(posedge clk);
        @(negedge clk);
        w_data = 24'h060504;
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL both_busy_load got %b exp 1", busy); end
        vectors++; if (x_ready !== 1'b0) begin miscompares++; $display("FAIL both_x_ready_load1 got %b exp 0", x_ready); end
        @(posedge clk);
        @(negedge clk);
        w_data = 24'h090807;
        #1;
        vectors++; if (x_ready !== 1'b0) begin miscompares++; $display("FAIL both_x_ready_load2 got %b exp 0", x_ready); end
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0; w_data = '0;
        #1;
        vectors++; if (x_ready !== 1'b1) begin miscompares++; $display("FAIL both_x_ready_stream got %b exp 1", x_ready); end
        vectors++; if (arr_w !== 72'h090807_060504_030201) begin miscompares++; $display("FAIL both_arr_w got %h exp 090807060504030201", arr_w); end
        x_valid = 1'b0; x_last = 1'b0; x_data = '0;
        xv.delete(); xl.delete();
        xv.push_back(24'h010101); xl.push_back(1'b1);
        run_stream(-1);
        vectors++; if (got_d.size() !== 1 || got_d[0] !== {16'd18, 16'd15, 16'd12}) begin
            miscompares++; $display("FAIL both_result got %h (n=%0d) exp 0012000f000c", (got_d.size() > 0) ? got_d[0] : 48'hx, got_d.size());
        end
        @(negedge clk);
    endtask

    task automatic test_weight_reuse();
        logic [47:0] g0, g1;
        xv.delete(); xl.delete();
        xv.push_back(24'h000001); xl.push_back(1'b0);
        xv.push_back(24'h020000); xl.push_back(1'b1);
        run_stream(-1);
        g0 = (got_d.size() > 0) ? got_d[0] : 48'hx;
        g1 = (got_d.size() > 1) ? got_d[1] : 48'hx;
        vectors++; if (g0 !== {16'd3, 16'd2, 16'd1}) begin miscompares++; $display("FAIL reuse_res0 got %h exp 000300020001", g0); end
        vectors++; if (g1 !== {16'd18, 16'd16, 16'd14}) begin miscompares++; $display("FAIL reuse_res1 got %h exp 00120010000e", g1); end
        vectors++; if (got_l.size() !== 2 || got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin miscompares++; $display("FAIL reuse_last got n=%0d exp 2 beats last on 2nd", got_l.size()); end
        @(negedge clk);
    endtask

    task automatic test_reset_drain();
        int k;
        int stale;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x_valid = 1'b1; x_data = 24'h010101; x_last = (i == 2);
            @(posedge clk);
        end
        @(negedge clk);
        x_valid = 1'b0; x_last = 1'b0; x_data = '0;
        k = 0;
        while (!res_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL rd_in_flight got res_valid %b exp 1", res_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy_drain got %b exp 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after_rst got %b exp 0", busy); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rd_res_valid_after_rst got %b exp 0", res_valid); end
        vectors++; if (arr_w !== '0) begin miscompares++; $display("FAIL rd_arr_w_after_rst got %h exp 0", arr_w); end
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid !== 1'b0) stale++;
        end
        vectors++; if (stale !== 0) begin miscompares++; $display("FAIL rd_stale_results got %0d exp 0", stale); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_stall();
        test_both_valid();
        test_weight_reuse();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1);
    end

endmodule
